// File: rtl/hand_sort_if.sv
// ---------------------------------------------------------------------------
// hand_sort_if
//   Groups every card-stream, sorter and status signal of hand_sort_ctrl.
//   The controller connects through the master modport; the environment
//   (upstream source, sorter, downstream sink) connects through slave.
//
//   Signals
//     card_in / card_valid / card_ready            upstream card stream
//     sort_start / sort_data                        request to the sorter
//     sort_done / sort_result                       reply from the sorter
//     card_out / card_out_valid / card_out_ready /
//     card_out_last                                 sorted card stream
//     busy / timeout_err                            status
// ---------------------------------------------------------------------------
interface hand_sort_if #(
  parameter int N_CARDS = 17,
  parameter int CARD_W  = 8
);
  localparam int HAND_W = N_CARDS * CARD_W;

  logic [CARD_W-1:0] card_in;
  logic              card_valid;
  logic              card_ready;

  logic              sort_start;
  logic [HAND_W-1:0] sort_data;
  logic              sort_done;
  logic [HAND_W-1:0] sort_result;

  logic [CARD_W-1:0] card_out;
  logic              card_out_valid;
  logic              card_out_ready;
  logic              card_out_last;

  logic              busy;
  logic              timeout_err;

  // Controller side.
  modport master (
    input  card_in, card_valid, sort_done, sort_result, card_out_ready,
    output card_ready, sort_start, sort_data, card_out, card_out_valid,
           card_out_last, busy, timeout_err
  );

  // Environment side: card source, sorter and card sink.
  modport slave (
    output card_in, card_valid, sort_done, sort_result, card_out_ready,
    input  card_ready, sort_start, sort_data, card_out, card_out_valid,
           card_out_last, busy, timeout_err
  );
endinterface

// File: rtl/hand_sort_ctrl.sv
// ---------------------------------------------------------------------------
// hand_sort_ctrl
//   Wraps an external sorter. Collects one hand of N_CARDS cards from the
//   upstream stream into a packed register, pulses sort_start for one cycle,
//   waits for sort_done (bounded by a TIMEOUT-cycle watchdog), captures the
//   sorted hand and streams it out smallest-first under valid/ready.
//
//   Parameters
//     N_CARDS  cards per hand
//     CARD_W   bits per card code
//     TIMEOUT  maximum cycles spent waiting for the sorter (>= 2)
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset; aborts any hand in progress
//     bus    hand_sort_if.master, see the interface for the signal list
// ---------------------------------------------------------------------------
module hand_sort_ctrl #(
  parameter int N_CARDS = 17,
  parameter int CARD_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  hand_sort_if.master  bus
);

  localparam int IDX_W = (N_CARDS > 1) ? $clog2(N_CARDS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CARDS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_STREAM  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // Packed [slot][bit]: slot k occupies bits [CARD_W*k +: CARD_W], which is
  // exactly the flat layout the sorter expects.
  logic [N_CARDS-1:0][CARD_W-1:0] hand_q;
  logic [N_CARDS-1:0][CARD_W-1:0] res_q;

  // Per-cycle events decoded by the FSM.
  logic card_acc;   // upstream card taken this cycle
  logic out_acc;    // downstream card taken this cycle
  logic load_res;   // sorter answered, capture its result
  logic abort;      // watchdog expired

  // -------------------------------------------------------------------------
  // Next-state and event decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    state_d  = state_q;
    card_acc = 1'b0;
    out_acc  = 1'b0;
    load_res = 1'b0;
    abort    = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        card_acc = bus.card_valid;
        if (card_acc && (wr_idx_q == LAST_IDX)) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A completion in the watchdog's final cycle still counts as success.
        if (bus.sort_done) begin
          load_res = 1'b1;
          state_d  = ST_STREAM;
        end else if (wait_cnt_q == LAST_WAIT) begin
          abort   = 1'b1;
          state_d = ST_COLLECT;
        end
      end

      ST_STREAM: begin
        out_acc = bus.card_out_ready;
        if (out_acc && (rd_idx_q == LAST_IDX)) begin
          state_d = ST_COLLECT;
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, indices and watchdog
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      timeout_q <= abort;

      if (card_acc) begin
        wr_idx_q <= (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
      end

      if (state_q == ST_START) begin
        wait_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end

      if (load_res) begin
        rd_idx_q <= '0;
      end else if (out_acc) begin
        rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hand and result storage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both storage arrays are reset because sort_data and card_out
      // are observable and must read as zero straight out of reset.
      hand_q <= '0;
      res_q  <= '0;
    end else begin
      if (card_acc) begin
        hand_q[wr_idx_q] <= bus.card_in;
      end
      if (load_res) begin
        res_q <= bus.sort_result;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // card_ready is held low while rst_n is asserted so that every output
  // reads zero during reset even though COLLECT is the reset state.
  assign bus.card_ready     = (state_q == ST_COLLECT) && rst_n;
  assign bus.sort_start     = (state_q == ST_START);
  assign bus.sort_data      = hand_q;
  assign bus.card_out_valid = (state_q == ST_STREAM);
  assign bus.card_out       = (state_q == ST_STREAM) ? res_q[rd_idx_q] : '0;
  assign bus.card_out_last  = (state_q == ST_STREAM) && (rd_idx_q == LAST_IDX);
  assign bus.busy           = (state_q != ST_COLLECT);
  assign bus.timeout_err    = timeout_q;

endmodule
